// File: rtl/alu_pwr_pkg.sv
// alu_pwr_pkg
// Shared types and helpers for the ALU power sequencer.
//   pwr_state_e  - sequencer state encoding (ON=0 .. RESTORE=6)
//   pwr_outs_t   - registered power-control outputs for one state
//   decode_outs  - Moore decode from a state to its power-control outputs
//   max3         - largest of three integers, used to size the counters
package alu_pwr_pkg;

  localparam int PWR_STATE_W = 3;

  typedef enum logic [PWR_STATE_W-1:0] {
    ST_ON      = 3'd0,
    ST_DRAIN   = 3'd1,
    ST_ISO     = 3'd2,
    ST_SAVE    = 3'd3,
    ST_OFF     = 3'd4,
    ST_PWRUP   = 3'd5,
    ST_RESTORE = 3'd6
  } pwr_state_e;

  typedef struct packed {
    logic alu_pwr_en;
    logic iso_en;
    logic save;
    logic restore;
    logic alu_on;
  } pwr_outs_t;

  // Isolation covers every state in which the ALU outputs may be invalid:
  // from the start of isolation until the retention restore has been issued.
  function automatic pwr_outs_t decode_outs(input pwr_state_e s);
    pwr_outs_t o;
    o.alu_pwr_en = (s != ST_OFF);
    o.iso_en     = (s inside {ST_ISO, ST_SAVE, ST_OFF, ST_PWRUP, ST_RESTORE});
    o.save       = (s == ST_SAVE);
    o.restore    = (s == ST_RESTORE);
    o.alu_on     = (s == ST_ON);
    return o;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/alu_pwr_timer.sv
// alu_pwr_timer
// Loadable down-counter shared by the isolation-setup and power-ramp phases.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load        - load the counter with value this cycle
//   value       - phase length in cycles (>= 1)
//   expire      - high during the last cycle of the phase (count == 1)
module alu_pwr_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] count;

  // Counting stops at zero so an idle timer never wraps and re-fires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (count != '0) begin
      count <= count - ONE;
    end
  end

  assign expire = (count == ONE);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// alu_pwr_ctrl
// Always-on power sequencer for the power-gated ALU domain.
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   sleep_req, wake_req    - level requests to power the ALU down / up
//   start_in               - requester start, held until accepted
//   start_ready, start_out - start handshake, open only while fully ON
//   alu_busy               - ALU busy flag, blocks draining into isolation
//   alu_pwr_en, iso_en     - registered power enable and output isolation
//   save, restore          - registered one-cycle retention pulses
//   pwr_state, alu_on      - registered state encoding and ON indicator
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int ISO_SETUP     = 2,
  parameter int PWR_UP_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sleep_req,
  input  logic                   wake_req,
  input  logic                   start_in,
  output logic                   start_ready,
  output logic                   start_out,
  input  logic                   alu_busy,
  output logic                   alu_pwr_en,
  output logic                   iso_en,
  output logic                   save,
  output logic                   restore,
  output logic [PWR_STATE_W-1:0] pwr_state,
  output logic                   alu_on
);

  localparam int CNT_W = $clog2(max3(ISO_SETUP, PWR_UP_CYCLES, IDLE_TIMEOUT) + 1);

  localparam logic [CNT_W-1:0] ISO_LOAD   = CNT_W'(ISO_SETUP);
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(PWR_UP_CYCLES);
  localparam logic [CNT_W-1:0] IDLE_LIMIT = CNT_W'(IDLE_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  pwr_state_e       state;
  pwr_state_e       state_nx;
  pwr_outs_t        outs_nx;
  logic [CNT_W-1:0] idle_cnt;
  logic             idle_hit;
  logic             wake_pend;
  logic             wake_any;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_expire;

  alu_pwr_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (timer_load),
    .value  (timer_value),
    .expire (timer_expire)
  );

  assign wake_any = wake_req | start_in;
  assign idle_hit = (IDLE_TIMEOUT != 0) && (idle_cnt == IDLE_LIMIT);

  // In ON a pending start or an explicit wake both hold the domain up, so
  // sleep only wins when neither is present. DRAIN/ISO/SAVE cannot be
  // aborted; any wake seen there is remembered in wake_pend and acted on
  // from OFF after a single cycle.
  always_comb begin
    state_nx    = state;
    timer_load  = 1'b0;
    timer_value = ISO_LOAD;
    case (state)
      ST_ON: begin
        if (!start_in && !wake_req && (sleep_req || idle_hit)) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!alu_busy) begin
          state_nx    = ST_ISO;
          timer_load  = 1'b1;
          timer_value = ISO_LOAD;
        end
      end
      ST_ISO: begin
        if (timer_expire) state_nx = ST_SAVE;
      end
      ST_SAVE: begin
        state_nx = ST_OFF;
      end
      ST_OFF: begin
        if (wake_any || wake_pend) begin
          state_nx    = ST_PWRUP;
          timer_load  = 1'b1;
          timer_value = PWRUP_LOAD;
        end
      end
      ST_PWRUP: begin
        if (timer_expire) state_nx = ST_RESTORE;
      end
      ST_RESTORE: begin
        state_nx = ST_ON;
      end
      default: begin
        state_nx = ST_ON;
      end
    endcase
    outs_nx = decode_outs(state_nx);
  end

  // Outputs are decoded from the next state so they register in the same
  // cycle as the state itself and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_ON;
      alu_pwr_en <= 1'b1;
      iso_en     <= 1'b0;
      save       <= 1'b0;
      restore    <= 1'b0;
      alu_on     <= 1'b1;
      idle_cnt   <= '0;
      wake_pend  <= 1'b0;
    end else begin
      state      <= state_nx;
      alu_pwr_en <= outs_nx.alu_pwr_en;
      iso_en     <= outs_nx.iso_en;
      save       <= outs_nx.save;
      restore    <= outs_nx.restore;
      alu_on     <= outs_nx.alu_on;

      if (state == ST_ON && !alu_busy && !start_in) begin
        if (idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + ONE;
      end else begin
        idle_cnt <= '0;
      end

      if (state inside {ST_DRAIN, ST_ISO, ST_SAVE}) begin
        if (wake_any) wake_pend <= 1'b1;
      end else if (state == ST_OFF) begin
        wake_pend <= 1'b0;
      end
    end
  end

  assign pwr_state   = state;
  assign start_ready = (state == ST_ON);
  assign start_out   = start_in & start_ready;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// tb_alu_pwr_ctrl
// Self-checking bench for alu_pwr_ctrl with ISO_SETUP=2, PWR_UP_CYCLES=3,
// IDLE_TIMEOUT=8. A reference model pushes the expected output vector for
// every driven cycle into a queue; the monitor pops it at the falling edge.
module tb_alu_pwr_ctrl;

  localparam int ISO_SETUP = 2;
  localparam int PWR_UP    = 3;
  localparam int IDLE_TO   = 8;

  localparam logic [2:0] S_ON      = 3'd0;
  localparam logic [2:0] S_DRAIN   = 3'd1;
  localparam logic [2:0] S_ISO     = 3'd2;
  localparam logic [2:0] S_SAVE    = 3'd3;
  localparam logic [2:0] S_OFF     = 3'd4;
  localparam logic [2:0] S_PWRUP   = 3'd5;
  localparam logic [2:0] S_RESTORE = 3'd6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sleep_req, wake_req, start_in, alu_busy;
  logic       start_ready, start_out;
  logic       alu_pwr_en, iso_en, save, restore, alu_on;
  logic [2:0] pwr_state;

  always #5 clk = ~clk;

  alu_pwr_ctrl #(
    .ISO_SETUP     (ISO_SETUP),
    .PWR_UP_CYCLES (PWR_UP),
    .IDLE_TIMEOUT  (IDLE_TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sleep_req   (sleep_req),
    .wake_req    (wake_req),
    .start_in    (start_in),
    .start_ready (start_ready),
    .start_out   (start_out),
    .alu_busy    (alu_busy),
    .alu_pwr_en  (alu_pwr_en),
    .iso_en      (iso_en),
    .save        (save),
    .restore     (restore),
    .pwr_state   (pwr_state),
    .alu_on      (alu_on)
  );

  int checks = 0;
  int passes = 0;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: state, cycles left in the current timed phase, idle
  // count and a remembered wake from the non-abortable power-down states.
  logic [2:0] m_state;
  int         m_rem;
  int         m_idle;
  bit         m_pend;

  logic [9:0] exp_q[$];

  function automatic logic [9:0] model_outs(input bit st);
    logic on_s;
    logic iso_s;
    on_s  = (m_state == S_ON);
    iso_s = (m_state == S_ISO) || (m_state == S_SAVE) || (m_state == S_OFF) ||
            (m_state == S_PWRUP) || (m_state == S_RESTORE);
    return {m_state, on_s, logic'(m_state != S_OFF), iso_s, logic'(m_state == S_SAVE),
            logic'(m_state == S_RESTORE), on_s, logic'(on_s & st)};
  endfunction

  task automatic model_step(input bit s, input bit w, input bit st, input bit b);
    logic [2:0] nx;
    nx = m_state;
    if (m_state == S_ON) begin
      if (!st && !w && (s || (IDLE_TO != 0 && m_idle == IDLE_TO))) nx = S_DRAIN;
      if (b || st) m_idle = 0;
      else if (m_idle < IDLE_TO) m_idle++;
    end else begin
      m_idle = 0;
      if ((m_state == S_DRAIN || m_state == S_ISO || m_state == S_SAVE) && (w || st)) m_pend = 1;
      case (m_state)
        S_DRAIN: if (!b) begin nx = S_ISO; m_rem = ISO_SETUP; end
        S_ISO:   if (m_rem == 1) nx = S_SAVE; else m_rem--;
        S_SAVE:  nx = S_OFF;
        S_OFF:   if (w || st || m_pend) begin nx = S_PWRUP; m_rem = PWR_UP; m_pend = 0; end
        S_PWRUP: if (m_rem == 1) nx = S_RESTORE; else m_rem--;
        default: nx = S_ON;
      endcase
    end
    m_state = nx;
  endtask

  // Invariant trackers and the latest observed sample.
  bit         prev_iso, prev_pwr, restore_seen;
  int         iso_run;
  logic [2:0] o_state;
  logic       o_pwr, o_iso, o_save, o_restore, o_ready, o_sout;

  task automatic reset_model();
    m_state = S_ON; m_rem = 0; m_idle = 0; m_pend = 0;
    prev_iso = 0; prev_pwr = 1; restore_seen = 0; iso_run = 0;
  endtask

  // Drive one cycle of inputs just after the rising edge, compare at the
  // falling edge, then advance to just after the next rising edge.
  task automatic apply_stimulus(input bit s, input bit w, input bit st, input bit b);
    sleep_req = s; wake_req = w; start_in = st; alu_busy = b;
    exp_q.push_back(model_outs(st));
    model_step(s, w, st, b);
    @(negedge clk);
    o_state = pwr_state; o_pwr = alu_pwr_en; o_iso = iso_en; o_save = save;
    o_restore = restore; o_ready = start_ready; o_sout = start_out;
    check_output("scoreboard", {o_state, alu_on, o_pwr, o_iso, o_save, o_restore, o_ready, o_sout},
                 exp_q.pop_front());
    check_output("save_restore_excl", save & restore, 0);
    check_output("start_gated", start_out & (pwr_state != S_ON), 0);
    if (prev_pwr && !alu_pwr_en) check_output("iso_lead", iso_run >= ISO_SETUP, 1);
    if (prev_iso && !iso_en) begin
      check_output("iso_fall_after_restore", restore_seen, 1);
      restore_seen = 0;
    end
    if (restore) restore_seen = 1;
    iso_run  = iso_en ? iso_run + 1 : 0;
    prev_iso = iso_en;
    prev_pwr = alu_pwr_en;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int drain_at, off_at, iso_rise, save_at, save_cnt, restore_cnt;
    int pwr_at, restore_at, sout_at, drain_cnt, iso_hi, off_len;
    logic [2:0] off_next;
    bit seen_off;

    rst_n = 1'b0; sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_alu_on", alu_on, 1);
    check_output("rst_pwr_en", alu_pwr_en, 1);
    check_output("rst_iso", iso_en, 0);
    check_output("rst_save_restore", {save, restore}, 0);
    check_output("rst_ready", start_ready, 1);
    check_output("rst_state", pwr_state, S_ON);
    rst_n = 1'b1;

    // Idle timeout into OFF.
    drain_at = -1; off_at = -1; iso_rise = -1; save_at = -1; save_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      apply_stimulus(0, 0, 0, 0);
      if (o_state == S_DRAIN && drain_at < 0) drain_at = c;
      if (o_iso && iso_rise < 0) iso_rise = c;
      if (o_save) begin save_cnt++; save_at = c; end
      if (o_state == S_OFF) begin off_at = c; break; end
    end
    check_output("idle_drain_cycle", drain_at, IDLE_TO + 1);
    check_output("idle_off_after_drain", off_at - drain_at, ISO_SETUP + 2);
    check_output("idle_save_after_iso", save_at - iso_rise, ISO_SETUP);
    check_output("idle_save_count", save_cnt, 1);

    // Start held in OFF wakes the domain and is accepted once ON.
    apply_stimulus(0, 0, 1, 0);
    check_output("off_start_ready", o_ready, 0);
    check_output("off_start_out", o_sout, 0);
    pwr_at = -1; restore_at = -1; sout_at = -1;
    for (int c = 1; c < 20; c++) begin
      apply_stimulus(0, 0, 1, 0);
      if (o_pwr && pwr_at < 0) pwr_at = c;
      if (o_restore) begin
        restore_at = c;
        check_output("restore_iso", o_iso, 1);
      end
      if (o_sout) begin sout_at = c; break; end
    end
    check_output("wake_pwr_en_next", pwr_at, 1);
    check_output("wake_restore_delay", restore_at - pwr_at, PWR_UP);
    check_output("wake_start_latency", sout_at, PWR_UP + 2);

    // Sleep while busy: DRAIN holds until the ALU goes idle.
    apply_stimulus(1, 0, 0, 1);
    drain_cnt = 0; iso_hi = 0;
    for (int c = 0; c < 5; c++) begin
      apply_stimulus(0, 0, 0, 1);
      if (o_state == S_DRAIN) drain_cnt++;
      if (o_iso) iso_hi++;
    end
    check_output("busy_drain_hold", drain_cnt, 5);
    check_output("busy_iso_low", iso_hi, 0);
    off_at = -1;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(0, 0, 0, 0);
      if (o_state == S_OFF) begin off_at = c; break; end
    end
    check_output("busy_off_latency", off_at, ISO_SETUP + 2);
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(0, 1, 0, 0);
      if (o_state == S_ON) break;
    end
    check_output("wake_req_back_on", o_state, S_ON);

    // Wake pulsed during ISO: finishes power-down, OFF for one cycle.
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    apply_stimulus(0, 1, 0, 0);
    check_output("pulse_in_iso", o_state, S_ISO);
    off_len = 0; save_cnt = 0; restore_cnt = 0; seen_off = 0; off_next = S_ON;
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(0, 0, 0, 0);
      if (o_save) save_cnt++;
      if (o_restore) restore_cnt++;
      if (o_state == S_OFF) begin off_len++; seen_off = 1; end
      else if (seen_off) begin off_next = o_state; seen_off = 0; end
      if (o_state == S_ON) break;
    end
    check_output("pulse_off_len", off_len, 1);
    check_output("pulse_off_next", off_next, S_PWRUP);
    check_output("pulse_save_count", save_cnt, 1);
    check_output("pulse_restore_count", restore_cnt, 1);

    // wake beats sleep; start beats sleep.
    apply_stimulus(1, 1, 0, 0);
    apply_stimulus(1, 1, 0, 0);
    check_output("wake_beats_sleep", o_state, S_ON);
    apply_stimulus(1, 0, 1, 0);
    check_output("start_beats_sleep_out", o_sout, 1);
    apply_stimulus(1, 0, 0, 0);
    check_output("start_beats_sleep_state", o_state, S_ON);
    apply_stimulus(1, 0, 0, 0);
    check_output("sleep_after_start", o_state, S_DRAIN);

    // Reset asserted in the middle of PWRUP.
    for (int c = 0; c < 20; c++) begin
      apply_stimulus(0, 0, 0, 0);
      if (o_state == S_OFF) break;
    end
    apply_stimulus(0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 0);
    check_output("pre_reset_pwrup", o_state, S_PWRUP);
    #3;
    rst_n = 1'b0;
    #1;
    check_output("midrst_pwr_en", alu_pwr_en, 1);
    check_output("midrst_iso", iso_en, 0);
    check_output("midrst_restore", restore, 0);
    check_output("midrst_state", pwr_state, S_ON);
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) apply_stimulus(0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
